ff_adc_sequencer: RTL and testbench

//   Emulates the ADC0809-style multiplexed converter that feeds the four

---
 rtl/ff_adc_sequencer_if.sv | 32 +++
 rtl/ff_adc_sequencer.sv | 96 +++++++++
 tb/tb_ff_adc_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ff_adc_sequencer_if.sv
// CPU-side bus of the stick ADC sequencer: analog inputs, start strobe and result readback.
interface ff_adc_sequencer_if;
  logic [31:0] AIN;
  logic        WR_START;
  logic [2:0]  WR_CH;
  logic [7:0]  DOUT;
  logic        EOC;
  logic        BUSY;
  logic [2:0]  CH_OUT;

  // Stick sources and CPU drive the inputs and read the result.
  modport master (
    output AIN,
    output WR_START,
    output WR_CH,
    input  DOUT,
    input  EOC,
    input  BUSY,
    input  CH_OUT
  );

  // Sequencer side.
  modport slave (
    input  AIN,
    input  WR_START,
    input  WR_CH,
    output DOUT,
    output EOC,
    output BUSY,
    output CH_OUT
  );
endinterface

// File: rtl/ff_adc_sequencer.sv
// ADC0809-style sequencer: a start latches a channel, the next cycle samples and holds it,
// then a fixed-length countdown runs before the held value is published with EOC.
module ff_adc_sequencer #(
  parameter int unsigned CONV_CYCLES = 4800
) (
  input  logic                 MCLK,
  input  logic                 RESET_N,
  ff_adc_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StSample, StConvert} state_e;

  localparam logic [15:0] CntLoad = 16'(CONV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        eoc_q, eoc_d;
  logic        busy_q, busy_d;
  logic [7:0]  ain_sel;

  // Channel mux; channels 4..7 have no source and read as zero.
  always_comb begin
    ain_sel = 8'h00;
    if (!ch_q[2]) begin
      ain_sel = bus.AIN[{ch_q[1:0], 3'b000} +: 8];
    end
  end

  // Next-state logic; a start strobe overrides whatever the FSM is doing, including completion.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    eoc_d   = eoc_q;
    busy_d  = busy_q;
    if (bus.WR_START) begin
      ch_d    = bus.WR_CH;
      eoc_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = StSample;
    end else begin
      case (state_q)
        StIdle: begin
        end
        StSample: begin
          hold_d  = ain_sel;
          cnt_d   = CntLoad;
          state_d = StConvert;
        end
        StConvert: begin
          if (cnt_q == 16'd0) begin
            dout_d  = hold_q;
            eoc_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      ch_q    <= 3'd0;
      hold_q  <= 8'h00;
      cnt_q   <= 16'd0;
      dout_q  <= 8'h00;
      eoc_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      eoc_q   <= eoc_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.DOUT   = dout_q;
  assign bus.EOC    = eoc_q;
  assign bus.BUSY   = busy_q;
  assign bus.CH_OUT = ch_q;

endmodule

// File: tb/tb_ff_adc_sequencer.sv
// Bench for ff_adc_sequencer: timeline model checked every cycle plus directed literal checks.
module tb_ff_adc_sequencer;

  localparam int unsigned C = 16;

  logic MCLK = 1'b0;
  logic RESET_N = 1'b0;
  logic clk_en = 1'b1;
  logic chk_en = 1'b0;
  int checks = 0;
  int failures = 0;

  ff_adc_sequencer_if bus ();

  ff_adc_sequencer #(.CONV_CYCLES(C)) dut (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) MCLK = ~MCLK;
    end
  end

  // Model: a conversion started at edge s samples at edge s+1 and completes at edge s+C+1,
  // unless a later start or a reset replaces it.
  int unsigned edge_n = 0;
  int unsigned m_start = 0;
  bit          m_active = 1'b0;
  logic [2:0]  m_ch = 3'd0;
  logic [7:0]  m_hold = 8'h00;
  logic [7:0]  m_dout = 8'h00;
  logic        m_eoc = 1'b1;
  logic        m_busy = 1'b0;

  always @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_active <= 1'b0;
      m_ch     <= 3'd0;
      m_hold   <= 8'h00;
      m_dout   <= 8'h00;
      m_eoc    <= 1'b1;
      m_busy   <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (bus.WR_START) begin
        m_active <= 1'b1;
        m_start  <= edge_n + 1;
        m_ch     <= bus.WR_CH;
        m_eoc    <= 1'b0;
        m_busy   <= 1'b1;
      end else if (m_active) begin
        if (edge_n == m_start) begin
          m_hold <= (m_ch < 3'd4) ? bus.AIN[m_ch*8 +: 8] : 8'h00;
        end
        if (edge_n == m_start + C) begin
          m_dout   <= m_hold;
          m_eoc    <= 1'b1;
          m_busy   <= 1'b0;
          m_active <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Compare process: outputs are settled by the falling edge.
  always @(negedge MCLK) begin
    if (chk_en) begin
      chk("model_dout", bus.DOUT, m_dout);
      chk("model_eoc", {7'd0, bus.EOC}, {7'd0, m_eoc});
      chk("model_busy", {7'd0, bus.BUSY}, {7'd0, m_busy});
      chk("model_ch", {5'd0, bus.CH_OUT}, {5'd0, m_ch});
    end
  end

  task automatic step();
    @(negedge MCLK);
    #1;
  endtask

  // Start strobe sampled on the next rising edge; returns just after that edge.
  task automatic start(input logic [2:0] ch);
    bus.WR_START = 1'b1;
    bus.WR_CH    = ch;
    step();
    bus.WR_START = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [7:0] dout, input logic eoc,
                         input logic busy, input logic [2:0] ch);
    chk({name, "_dout"}, bus.DOUT, dout);
    chk({name, "_eoc"}, {7'd0, bus.EOC}, {7'd0, eoc});
    chk({name, "_busy"}, {7'd0, bus.BUSY}, {7'd0, busy});
    chk({name, "_ch"}, {5'd0, bus.CH_OUT}, {5'd0, ch});
  endtask

  localparam logic [31:0] AinDefault = 32'h7EC3_5A11;

  initial begin
    bus.AIN      = AinDefault;
    bus.WR_START = 1'b0;
    bus.WR_CH    = 3'd0;
    repeat (3) step();
    chk_out("reset", 8'h00, 1'b1, 1'b0, 3'd0);
    RESET_N = 1'b1;
    chk_en  = 1'b1;
    step();

    // Basic conversion of channel 1.
    start(3'd1);
    chk_out("basic_t", 8'h00, 1'b0, 1'b1, 3'd1);
    repeat (C) step();
    chk_out("basic_t16", 8'h00, 1'b0, 1'b1, 3'd1);
    step();
    chk_out("basic_t17", 8'h5A, 1'b1, 1'b0, 3'd1);

    // Abort: ch0 replaced by ch2 five edges in; 8'h11 must never appear.
    repeat (2) step();
    start(3'd0);
    repeat (4) step();
    start(3'd2);
    repeat (C) step();
    chk_out("abort_t21", 8'h5A, 1'b0, 1'b1, 3'd2);
    step();
    chk_out("abort_t22", 8'hC3, 1'b1, 1'b0, 3'd2);

    // Start coinciding with the completion edge of a ch1 conversion.
    repeat (2) step();
    start(3'd1);
    repeat (C) step();
    start(3'd3);
    chk_out("coinc_t17", 8'hC3, 1'b0, 1'b1, 3'd3);
    repeat (C) step();
    chk_out("coinc_t33", 8'hC3, 1'b0, 1'b1, 3'd3);
    step();
    chk_out("coinc_t34", 8'h7E, 1'b1, 1'b0, 3'd3);

    // Sample-and-hold: input changes after the sample edge are ignored.
    repeat (2) step();
    start(3'd1);
    repeat (2) step();
    bus.AIN = 32'h7EC3_3311;
    repeat (C - 2) step();
    chk_out("hold_t16", 8'h7E, 1'b0, 1'b1, 3'd1);
    step();
    chk_out("hold_t17", 8'h5A, 1'b1, 1'b0, 3'd1);
    bus.AIN = AinDefault;

    // Unused channel converts to zero with normal timing.
    repeat (2) step();
    start(3'd5);
    repeat (C) step();
    chk_out("unused_t16", 8'h5A, 1'b0, 1'b1, 3'd5);
    step();
    chk_out("unused_t17", 8'h00, 1'b1, 1'b0, 3'd5);

    // Reset mid-conversion, with the clock running.
    repeat (2) step();
    start(3'd1);
    repeat (7) step();
    RESET_N = 1'b0;
    #1;
    chk_out("rst_mid", 8'h00, 1'b1, 1'b0, 3'd0);
    step();
    RESET_N = 1'b1;
    repeat (C + 4) step();
    chk_out("rst_after", 8'h00, 1'b1, 1'b0, 3'd0);

    // Reset asserted and released with the clock stopped.
    start(3'd2);
    repeat (C + 1) step();
    start(3'd3);
    chk_out("async_pre", 8'hC3, 1'b0, 1'b1, 3'd3);
    clk_en = 1'b0;
    #20;
    RESET_N = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b1, 1'b0, 3'd0);
    #10;
    RESET_N = 1'b1;
    #9;
    clk_en = 1'b1;
    repeat (C + 4) step();
    chk_out("async_after", 8'h00, 1'b1, 1'b0, 3'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
